// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start in IDLE captures bin; bcd/overflow update together with the done pulse.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shreg_shifted;
    logic [BW-1:0]     scratch;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_shifted;
    logic              sticky;
    logic              sticky_next;
    logic [CW-1:0]     cnt;
    logic              last_bit;

    // Add-3 correction on every digit, then one combined left shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_shifted = {adj[BW-2:0], shreg[WIDTH-1]};
        shreg_shifted   = {shreg[WIDTH-2:0], 1'b0};
        sticky_next     = sticky | adj[BW-1];
        last_bit        = (cnt == CW'(1));
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == FINISH);
        unique case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: a small register set rather than a memory, so every element is reset explicitly.
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers see pre-edge values.
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    shreg   <= shreg_shifted;
                    scratch <= scratch_shifted;
                    sticky  <= sticky_next;
                    cnt     <= cnt - CW'(1);
                    // Result lands on the edge into FINISH so it is valid during done.
                    if (last_bit) begin
                        bcd      <= scratch_shifted;
                        overflow <= sticky_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
